axilite_timer_slave: RTL and testbench
======================================

Name: axilite_timer_slave

Overview:
AXI-Lite responder (slave) for the timer register block; sits at the far end of the bus that the bench's AXI-Lite master driver initiates on. Accepts single-beat reads and writes and decodes four 32-bit registers: CNT control, TLR load, TCR count, TIR interrupt. Produces per-register update strobes and field values toward the timer core, and samples the live count and zero-event from the core.

Parameters:
ADDR_WIDTH, 32, AXI address width; minimum 4.
DATA_WIDTH, 32, AXI data width; fixed at 32, and elaboration fails on any other value.

Ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-low
aw_addr  in  ADDR_WIDTH  write address
aw_prot  in  3  ignored
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
w_data  in  32  write data
w_strb  in  4  byte enables
w_valid  in  1  write data valid
w_ready  out  1  write data ready
b_resp  out  2  write response; 00=OKAY, 10=SLVERR
b_valid  out  1  write response valid
b_ready  in  1  write response ready
ar_addr  in  ADDR_WIDTH  read address
ar_prot  in  3  ignored
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
r_data  out  32  read data
r_resp  out  2  read response
r_valid  out  1  read valid
r_ready  in  1  read ready
cnt_strobe  out  1  one-cycle pulse when CNT is written
cnt_ena  out  1  CNT[0], count enable
cnt_udt  out  1  CNT[1], up/down select
cnt_ien  out  1  CNT[2], interrupt enable
tlr_strobe  out  1  one-cycle pulse when TLR is written
tlr_tlr  out  32  TLR value
tcr_strobe  out  1  one-cycle pulse when a TCR read is accepted
tcr_tcr  in  32  live count from the timer core
tir_zero_set  in  1  one-cycle zero event from the core
irq  out  1  interrupt: TIR[0] & cnt_ien

Behaviour:
- Reset (rst=0, asynchronous):
  - All readys = 0 while in reset.
  - All valids, strobes and irq = 0; b_resp = r_resp = 00; r_data = 0.
  - CNT = 0, TLR = 0, TIR = 0; address/data holding flags cleared.
- Reset mid-transaction aborts it. No response is issued after reset releases.
- Register map, decoded from addr[3:2] with addr[1:0] ignored:
  - 0x0 CNT: RW, bits[2:0]; other bits read 0.
  - 0x4 TLR: RW, 32 bits.
  - 0x8 TCR: RO; returns tcr_tcr sampled at the AR handshake. Writes are ignored and return OKAY.
  - 0xC TIR: bit0 = zero flag, W1C.
  - addr[ADDR_WIDTH-1:4] != 0: unmapped. The access returns SLVERR; writes change nothing and reads return 0.
- Write path: AW and W are independent and may arrive in either order or the same cycle.
  - aw_ready = !aw_held & !b_valid; w_ready = !w_held & !b_valid. Each handshake latches its address or data+strb into a holding register.
  - Commit at the first edge where aw_held & w_held & !b_valid. At that edge:
    - The register updates per byte under w_strb.
    - b_valid rises with b_resp set.
    - Holding flags clear.
    - cnt_strobe / tlr_strobe is high for exactly the following cycle.
  - A strobe fires whenever the addressed register is CNT or TLR and the response is OKAY, even if w_strb=0.
  - b_valid holds until b_ready. The next write cannot commit until then, giving one outstanding write.
  - Minimum latency: AW+W in cycle N gives b_valid in cycle N+2.
- Read path:
  - ar_ready = !r_valid.
  - An AR handshake at edge N registers r_data/r_resp and sets r_valid in cycle N+1. tcr_strobe pulses in cycle N+1 if the address is TCR.
  - r_valid, r_data and r_resp are held stable until r_ready.
  - Reads and writes proceed concurrently and independently.
- TIR[0]:
  - Set by tir_zero_set.
  - Cleared by a committed write to TIR with w_strb[0]=1 and w_data[0]=1.
  - A set and a clear in the same cycle leaves the flag set.
- irq is combinational from the registered TIR[0] and CNT[2].
- A read of TIR in the same cycle as tir_zero_set returns the pre-set value.

Decomposition:
- Package axilite_timer_pkg holds:
  - Offsets CNT_OFS=4'h0, TLR_OFS=4'h4, TCR_OFS=4'h8, TIR_OFS=4'hC.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - A typedef for the CNT field struct {ien, udt, ena}.
- One sub-module, axilite_timer_regfile: holds the register storage, byte-strobe merge, W1C/set priority and read mux. The top level keeps the AXI handshake logic.

Test Plan:
- Reset then write 0x0000_0005 to 0x0 with strb=F, AW and W in the same cycle:
  - b_valid in cycle N+2 with OKAY.
  - cnt_ena=1, cnt_udt=0, cnt_ien=1.
  - cnt_strobe high for exactly 1 cycle.
- W presented 3 cycles before AW, writing 0xDEAD_BEEF to 0x4 with strb=4'b0011: tlr_tlr=0x0000_BEEF, tlr_strobe pulses once, b_resp=OKAY.
- tcr_tcr=0x1234_5678, read 0x8 with r_ready held low 4 cycles: r_data=0x1234_5678 stable throughout, tcr_strobe pulses once, ar_ready=0 until the r handshake.
- Pulse tir_zero_set with CNT.ien=1:
  - irq=1 and a read of 0xC returns 0x1.
  - Write 0x1 to 0xC while tir_zero_set=1 in the commit cycle: flag stays 1.
  - Repeat without tir_zero_set: flag and irq go to 0.
- Write and read to 0x10:
  - Both return SLVERR and no strobe fires.
  - Registers are unchanged; r_data=0.
- Assert rst low while AW is held and W has not yet arrived, then release:
  - b_valid stays 0 and all outputs are at reset values.
  - A subsequent full write completes normally.

Source files
------------

// File: rtl/axilite_timer_slave_pkg.sv
// Shared constants and types for the AXI-Lite timer register block.
// Register offsets, response codes and the CNT field layout live here.
package axilite_timer_pkg;

  localparam logic [3:0] CNT_OFS = 4'h0;
  localparam logic [3:0] TLR_OFS = 4'h4;
  localparam logic [3:0] TCR_OFS = 4'h8;
  localparam logic [3:0] TIR_OFS = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic ien;
    logic udt;
    logic ena;
  } cnt_t;

  typedef enum logic [1:0] {
    REG_CNT = 2'd0,
    REG_TLR = 2'd1,
    REG_TCR = 2'd2,
    REG_TIR = 2'd3
  } reg_sel_e;

  // Word select comes from addr[3:2]; the byte lane bits never take part.
  function automatic reg_sel_e reg_decode(input logic [1:0] word);
    logic [3:0] ofs;
    ofs = {word, 2'b00};
    if (ofs == CNT_OFS)      return REG_CNT;
    else if (ofs == TLR_OFS) return REG_TLR;
    else if (ofs == TCR_OFS) return REG_TCR;
    else                     return REG_TIR;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axilite_timer_slave_if.sv
// AXI-Lite bus bundle between the bench master and the timer register slave.
interface axilite_timer_slave_if #(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [31:0]           r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid,    input w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input r_ready
  );

endinterface

// File: rtl/axilite_timer_slave_regfile.sv
// Timer register storage: CNT/TLR with byte-strobe merge, TIR zero flag with
// set-over-clear priority, and the combinational read mux.
module axilite_timer_regfile
  import axilite_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  reg_sel_e    wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  input  reg_sel_e    rd_sel_i,
  input  logic [31:0] tcr_i,
  input  logic        zero_set_i,
  output cnt_t        cnt_o,
  output logic [31:0] tlr_o,
  output logic        tir_o,
  output logic [31:0] rd_data_o
);

  cnt_t        cnt_q, cnt_d;
  logic [31:0] tlr_q, tlr_d;
  logic        tir_q, tir_d;
  logic        tir_clr;

  always_comb begin
    cnt_d = cnt_q;
    tlr_d = tlr_q;
    if (wr_en_i && (wr_sel_i == REG_CNT) && wr_strb_i[0]) begin
      cnt_d = cnt_t'(wr_data_i[2:0]);
    end
    if (wr_en_i && (wr_sel_i == REG_TLR)) begin
      tlr_d = strb_merge(tlr_q, wr_data_i, wr_strb_i);
    end
  end

  // A zero event in the same cycle as a W1C must win so no event is lost.
  assign tir_clr = wr_en_i && (wr_sel_i == REG_TIR) && wr_strb_i[0] && wr_data_i[0];
  assign tir_d   = zero_set_i | (tir_q & ~tir_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tlr_q <= '0;
      tir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tlr_q <= tlr_d;
      tir_q <= tir_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    unique case (rd_sel_i)
      REG_CNT: rd_data_o = {29'd0, cnt_q};
      REG_TLR: rd_data_o = tlr_q;
      REG_TCR: rd_data_o = tcr_i;
      REG_TIR: rd_data_o = {31'd0, tir_q};
      default: rd_data_o = '0;
    endcase
  end

  assign cnt_o = cnt_q;
  assign tlr_o = tlr_q;
  assign tir_o = tir_q;

endmodule

// File: rtl/axilite_timer_slave.sv
// AXI-Lite slave front end for the timer: independent AW/W holding registers,
// one outstanding write, single-entry read response, strobes toward the core.
module axilite_timer_slave
  import axilite_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  axilite_timer_slave_if.slave s_axi,
  output logic                 cnt_strobe,
  output logic                 cnt_ena,
  output logic                 cnt_udt,
  output logic                 cnt_ien,
  output logic                 tlr_strobe,
  output logic [31:0]          tlr_tlr,
  output logic                 tcr_strobe,
  input  logic [31:0]          tcr_tcr,
  input  logic                 tir_zero_set,
  output logic                 irq
);

  if (DATA_WIDTH != 32) begin : g_dw_check
    $error("axilite_timer_slave: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 4) begin : g_aw_check
    $error("axilite_timer_slave: ADDR_WIDTH must be at least 4");
  end

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  logic [31:0]           r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  cnt_strobe_q, cnt_strobe_d;
  logic                  tlr_strobe_q, tlr_strobe_d;
  logic                  tcr_strobe_q, tcr_strobe_d;

  logic        aw_ready, w_ready, ar_ready;
  logic        aw_hs, w_hs, ar_hs;
  logic        commit;
  logic        wr_unmapped, rd_unmapped;
  reg_sel_e    wr_sel, rd_sel;
  logic [31:0] rd_data;
  cnt_t        cnt;
  logic        tir;
  logic        unused_bits;

  // Readys are forced low while reset is held, independent of register state.
  assign aw_ready = rst & ~aw_held_q & ~b_valid_q;
  assign w_ready  = rst & ~w_held_q  & ~b_valid_q;
  assign ar_ready = rst & ~r_valid_q;

  assign aw_hs  = s_axi.aw_valid & aw_ready;
  assign w_hs   = s_axi.w_valid  & w_ready;
  assign ar_hs  = s_axi.ar_valid & ar_ready;
  assign commit = aw_held_q & w_held_q & ~b_valid_q;

  assign wr_unmapped = |(aw_addr_q >> 4);
  assign rd_unmapped = |(s_axi.ar_addr >> 4);
  assign wr_sel      = reg_decode(aw_addr_q[3:2]);
  assign rd_sel      = reg_decode(s_axi.ar_addr[3:2]);

  assign unused_bits = ^{s_axi.aw_prot, s_axi.ar_prot, aw_addr_q[1:0], s_axi.ar_addr[1:0]};

  axilite_timer_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (commit & ~wr_unmapped),
    .wr_sel_i   (wr_sel),
    .wr_data_i  (w_data_q),
    .wr_strb_i  (w_strb_q),
    .rd_sel_i   (rd_sel),
    .tcr_i      (tcr_tcr),
    .zero_set_i (tir_zero_set),
    .cnt_o      (cnt),
    .tlr_o      (tlr_tlr),
    .tir_o      (tir),
    .rd_data_o  (rd_data)
  );

  always_comb begin
    aw_held_d    = aw_held_q;
    aw_addr_d    = aw_addr_q;
    w_held_d     = w_held_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    b_valid_d    = b_valid_q;
    b_resp_d     = b_resp_q;
    r_valid_d    = r_valid_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    cnt_strobe_d = 1'b0;
    tlr_strobe_d = 1'b0;
    tcr_strobe_d = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi.aw_addr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.w_data;
      w_strb_d = s_axi.w_strb;
    end

    // Strobes fire on any OKAY write to CNT/TLR, even with all strobes low.
    if (commit) begin
      aw_held_d    = 1'b0;
      w_held_d     = 1'b0;
      b_valid_d    = 1'b1;
      b_resp_d     = wr_unmapped ? RESP_SLVERR : RESP_OKAY;
      cnt_strobe_d = ~wr_unmapped & (wr_sel == REG_CNT);
      tlr_strobe_d = ~wr_unmapped & (wr_sel == REG_TLR);
    end else if (b_valid_q & s_axi.b_ready) begin
      b_valid_d = 1'b0;
    end

    if (ar_hs) begin
      r_valid_d    = 1'b1;
      r_data_d     = rd_unmapped ? 32'd0 : rd_data;
      r_resp_d     = rd_unmapped ? RESP_SLVERR : RESP_OKAY;
      tcr_strobe_d = ~rd_unmapped & (rd_sel == REG_TCR);
    end else if (r_valid_q & s_axi.r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held_q    <= 1'b0;
      aw_addr_q    <= '0;
      w_held_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      b_valid_q    <= 1'b0;
      b_resp_q     <= RESP_OKAY;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      r_resp_q     <= RESP_OKAY;
      cnt_strobe_q <= 1'b0;
      tlr_strobe_q <= 1'b0;
      tcr_strobe_q <= 1'b0;
    end else begin
      aw_held_q    <= aw_held_d;
      aw_addr_q    <= aw_addr_d;
      w_held_q     <= w_held_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      b_valid_q    <= b_valid_d;
      b_resp_q     <= b_resp_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_resp_q     <= r_resp_d;
      cnt_strobe_q <= cnt_strobe_d;
      tlr_strobe_q <= tlr_strobe_d;
      tcr_strobe_q <= tcr_strobe_d;
    end
  end

  assign s_axi.aw_ready = aw_ready;
  assign s_axi.w_ready  = w_ready;
  assign s_axi.b_valid  = b_valid_q;
  assign s_axi.b_resp   = b_resp_q;
  assign s_axi.ar_ready = ar_ready;
  assign s_axi.r_valid  = r_valid_q;
  assign s_axi.r_data   = r_data_q;
  assign s_axi.r_resp   = r_resp_q;

  assign cnt_strobe = cnt_strobe_q;
  assign tlr_strobe = tlr_strobe_q;
  assign tcr_strobe = tcr_strobe_q;
  assign cnt_ena    = cnt.ena;
  assign cnt_udt    = cnt.udt;
  assign cnt_ien    = cnt.ien;
  assign irq        = tir & cnt.ien;

endmodule

// File: tb/tb_axilite_timer_slave.sv
// Bench for axilite_timer_slave: directed vector table, hand-built corner
// sequences, then random traffic against a register-level reference model.
module tb_axilite_timer_slave;
  import axilite_timer_pkg::*;

  localparam int AW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_strobe, cnt_ena, cnt_udt, cnt_ien;
  logic        tlr_strobe, tcr_strobe, irq;
  logic [31:0] tlr_tlr;
  logic [31:0] tcr_tcr;
  logic        tir_zero_set;

  axilite_timer_slave_if #(.ADDR_WIDTH(AW)) bus ();

  axilite_timer_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi        (bus),
    .cnt_strobe   (cnt_strobe),
    .cnt_ena      (cnt_ena),
    .cnt_udt      (cnt_udt),
    .cnt_ien      (cnt_ien),
    .tlr_strobe   (tlr_strobe),
    .tlr_tlr      (tlr_tlr),
    .tcr_strobe   (tcr_strobe),
    .tcr_tcr      (tcr_tcr),
    .tir_zero_set (tir_zero_set),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_cnt_stb = 0, n_tlr_stb = 0, n_tcr_stb = 0;

  always @(posedge clk) begin
    if (cnt_strobe) n_cnt_stb <= n_cnt_stb + 1;
    if (tlr_strobe) n_tlr_stb <= n_tlr_stb + 1;
    if (tcr_strobe) n_tcr_stb <= n_tcr_stb + 1;
  end

  // Reference model: plain register contents and expected strobe counts.
  logic [2:0]  m_cnt;
  logic [31:0] m_tlr;
  logic        m_tir;
  int          m_cstb, m_tstb, m_rstb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    resp = RESP_OKAY;
    if ((addr >> 4) != 0) resp = RESP_SLVERR;
    else begin
      case (addr[3:2])
        2'd0: begin
          if (strb[0]) m_cnt = data[2:0];
          m_cstb++;
        end
        2'd1: begin
          for (int b = 0; b < 4; b++) if (strb[b]) m_tlr[8*b +: 8] = data[8*b +: 8];
          m_tstb++;
        end
        2'd2: ;
        default: if (strb[0] && data[0]) m_tir = 1'b0;
      endcase
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    resp = RESP_OKAY;
    data = 32'd0;
    if ((addr >> 4) != 0) resp = RESP_SLVERR;
    else begin
      case (addr[3:2])
        2'd0:    data = {29'd0, m_cnt};
        2'd1:    data = m_tlr;
        2'd2:    begin data = tcr_tcr; m_rstb++; end
        default: data = {31'd0, m_tir};
      endcase
    end
  endtask

  task automatic check_model_outputs(input string tag);
    chk({tag, " cnt_fields"}, {29'd0, cnt_ien, cnt_udt, cnt_ena}, {29'd0, m_cnt});
    chk({tag, " tlr_tlr"}, tlr_tlr, m_tlr);
    chk({tag, " irq"}, {31'd0, irq}, {31'd0, m_tir & m_cnt[2]});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " readys"}, {29'd0, bus.aw_ready, bus.w_ready, bus.ar_ready}, 32'd0);
    chk({tag, " valids"}, {30'd0, bus.b_valid, bus.r_valid}, 32'd0);
    chk({tag, " strobes_irq"}, {28'd0, cnt_strobe, tlr_strobe, tcr_strobe, irq}, 32'd0);
    chk({tag, " resps"}, {28'd0, bus.b_resp, bus.r_resp}, 32'd0);
    chk({tag, " r_data"}, bus.r_data, 32'd0);
    chk({tag, " cnt_fields"}, {29'd0, cnt_ien, cnt_udt, cnt_ena}, 32'd0);
    chk({tag, " tlr_tlr"}, tlr_tlr, 32'd0);
  endtask

  // Drives AW and W with independent start delays; lat counts edges from the
  // last address/data handshake to b_valid being seen.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0; w_done = 0; c = 0; lat = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && c < 40) begin
      bus.aw_valid = !aw_done && (c >= aw_dly);
      bus.aw_addr  = addr;
      bus.w_valid  = !w_done && (c >= w_dly);
      bus.w_data   = data;
      bus.w_strb   = strb;
      aw_hs = bus.aw_valid && bus.aw_ready;
      w_hs  = bus.w_valid && bus.w_ready;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("write addr/data handshake timeout", 32'd0, 32'd1);
      return;
    end
    while (!bus.b_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.b_valid) begin
      chk("b_valid timeout", 32'd0, 32'd1);
      return;
    end
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
  endtask

  // Holds r_ready low for 'hold' cycles after r_valid, checking stability.
  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int t;
    t = 0; data = 'x; resp = 2'bxx;
    bus.ar_addr  = addr;
    bus.ar_valid = 1'b1;
    while (!bus.ar_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    if (t >= 20 || !bus.r_valid) begin
      chk("read response timeout", {31'd0, bus.r_valid}, 32'd1);
      return;
    end
    data = bus.r_data;
    resp = bus.r_resp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("r_data held", bus.r_data, data);
      chk("r_valid/ar_ready held", {30'd0, bus.r_valid, bus.ar_ready}, 32'd2);
    end
    bus.r_ready = 1'b1;
    @(posedge clk); #1;
    bus.r_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rresp;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_tlr;
    int          exp_cstb;
    int          exp_tstb;
    int          exp_rstb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] rd, erd, addr, data;
    logic [3:0]  strb;
    int          lat, c0, t0, r0;

    vecs[0] = '{32'h0,    32'h0000_0005, 4'hF, 0, 0, RESP_OKAY,   32'h0000_0005, RESP_OKAY,   3'b101, 32'h0000_0000, 1, 0, 0};
    vecs[1] = '{32'h4,    32'hDEAD_BEEF, 4'h3, 3, 0, RESP_OKAY,   32'h0000_BEEF, RESP_OKAY,   3'b101, 32'h0000_BEEF, 0, 1, 0};
    vecs[2] = '{32'h4,    32'h1234_5678, 4'hC, 0, 1, RESP_OKAY,   32'h1234_BEEF, RESP_OKAY,   3'b101, 32'h1234_BEEF, 0, 1, 0};
    vecs[3] = '{32'h8,    32'hFFFF_FFFF, 4'hF, 1, 1, RESP_OKAY,   32'hA5A5_0001, RESP_OKAY,   3'b101, 32'h1234_BEEF, 0, 0, 1};
    vecs[4] = '{32'h10,   32'hFFFF_FFFF, 4'hF, 0, 2, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR, 3'b101, 32'h1234_BEEF, 0, 0, 0};
    vecs[5] = '{32'h3,    32'hFFFF_FFF2, 4'hF, 2, 2, RESP_OKAY,   32'h0000_0002, RESP_OKAY,   3'b010, 32'h1234_BEEF, 1, 0, 0};
    vecs[6] = '{32'h0,    32'h0000_0007, 4'h0, 0, 0, RESP_OKAY,   32'h0000_0002, RESP_OKAY,   3'b010, 32'h1234_BEEF, 1, 0, 0};
    vecs[7] = '{32'h1004, 32'h0000_0000, 4'hF, 1, 0, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR, 3'b010, 32'h1234_BEEF, 0, 0, 0};
    vecs[8] = '{32'hC,    32'h0000_0001, 4'hF, 0, 0, RESP_OKAY,   32'h0000_0000, RESP_OKAY,   3'b010, 32'h1234_BEEF, 0, 0, 0};

    rst = 1'b0;
    bus.aw_addr = '0; bus.aw_prot = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_prot = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
    tcr_tcr = 32'hA5A5_0001;
    tir_zero_set = 1'b0;
    m_cnt = '0; m_tlr = '0; m_tir = 1'b0; m_cstb = 0; m_tstb = 0; m_rstb = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table: write, then read back the same address.
    for (int i = 0; i < 9; i++) begin
      c0 = n_cnt_stb; t0 = n_tlr_stb; r0 = n_tcr_stb;
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, resp, lat);
      model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, eresp);
      chk($sformatf("vec%0d b_resp", i), {30'd0, resp}, {30'd0, vecs[i].exp_bresp});
      chk($sformatf("vec%0d b latency", i), lat, 32'd1);
      chk($sformatf("vec%0d cnt_fields", i), {29'd0, cnt_ien, cnt_udt, cnt_ena}, {29'd0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d tlr_tlr", i), tlr_tlr, vecs[i].exp_tlr);
      axi_read(vecs[i].addr, i % 3, rd, resp);
      chk($sformatf("vec%0d r_data", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d r_resp", i), {30'd0, resp}, {30'd0, vecs[i].exp_rresp});
      chk($sformatf("vec%0d cnt_strobe count", i), n_cnt_stb - c0, vecs[i].exp_cstb);
      chk($sformatf("vec%0d tlr_strobe count", i), n_tlr_stb - t0, vecs[i].exp_tstb);
      chk($sformatf("vec%0d tcr_strobe count", i), n_tcr_stb - r0, vecs[i].exp_rstb);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, 32'd0);
    end

    // TCR read with r_ready withheld for four cycles.
    tcr_tcr = 32'h1234_5678;
    r0 = n_tcr_stb;
    axi_read(32'h8, 4, rd, resp);
    chk("tcr hold r_data", rd, 32'h1234_5678);
    chk("tcr hold strobe count", n_tcr_stb - r0, 32'd1);

    // Zero event with interrupts enabled.
    axi_write(32'h0, 32'h4, 4'hF, 0, 0, resp, lat);
    tir_zero_set = 1'b1;
    @(posedge clk); #1;
    tir_zero_set = 1'b0;
    chk("irq after zero event", {31'd0, irq}, 32'd1);
    axi_read(32'hC, 0, rd, resp);
    chk("tir read after zero event", rd, 32'd1);

    // W1C committing in the same cycle as a new zero event keeps the flag.
    bus.aw_addr = 32'hC; bus.aw_valid = 1'b1;
    bus.w_data = 32'h1; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    tir_zero_set = 1'b1;
    @(posedge clk); #1;
    tir_zero_set = 1'b0;
    chk("set+clear b_valid", {31'd0, bus.b_valid}, 32'd1);
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    axi_read(32'hC, 0, rd, resp);
    chk("tir after set+clear", rd, 32'd1);
    chk("irq after set+clear", {31'd0, irq}, 32'd1);

    axi_write(32'hC, 32'h1, 4'hF, 0, 0, resp, lat);
    chk("tir clear b_resp", {30'd0, resp}, {30'd0, RESP_OKAY});
    axi_read(32'hC, 0, rd, resp);
    chk("tir after clear", rd, 32'd0);
    chk("irq after clear", {31'd0, irq}, 32'd0);

    // TIR read accepted in the same cycle as a zero event returns the old flag.
    bus.ar_addr = 32'hC; bus.ar_valid = 1'b1;
    tir_zero_set = 1'b1;
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    tir_zero_set = 1'b0;
    chk("tir same-cycle read", bus.r_data, 32'd0);
    chk("irq after same-cycle event", {31'd0, irq}, 32'd1);
    bus.r_ready = 1'b1;
    @(posedge clk); #1;
    bus.r_ready = 1'b0;
    axi_read(32'hC, 0, rd, resp);
    chk("tir after same-cycle event", rd, 32'd1);

    // Reset while AW is held and W is still missing.
    bus.aw_addr = 32'h4; bus.aw_valid = 1'b1;
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid-write reset");
    @(posedge clk); #1;
    rst = 1'b1;
    c0 = n_cnt_stb; t0 = n_tlr_stb;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no response after reset", {31'd0, bus.b_valid}, 32'd0);
    end
    chk("no strobes after reset", (n_cnt_stb - c0) + (n_tlr_stb - t0), 32'd0);
    m_cnt = '0; m_tlr = '0; m_tir = 1'b0;
    axi_write(32'h4, 32'hCAFE_F00D, 4'hF, 1, 0, resp, lat);
    model_write(32'h4, 32'hCAFE_F00D, 4'hF, eresp);
    chk("post-reset write b_resp", {30'd0, resp}, {30'd0, RESP_OKAY});
    chk("post-reset tlr_tlr", tlr_tlr, 32'hCAFE_F00D);
    chk("post-reset tlr_strobe count", n_tlr_stb - t0, 32'd1);

    // Random traffic against the reference model.
    m_cstb = 0; m_tstb = 0; m_rstb = 0;
    c0 = n_cnt_stb; t0 = n_tlr_stb; r0 = n_tcr_stb;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        tir_zero_set = 1'b1;
        @(posedge clk); #1;
        tir_zero_set = 1'b0;
        m_tir = 1'b1;
      end
      case ($urandom_range(0, 5))
        0, 1, 2, 3: begin
          addr = 32'($urandom_range(0, 3) * 4);
          addr = addr | 32'($urandom_range(0, 3));
        end
        4:       addr = 32'h10 << $urandom_range(0, 27);
        default: addr = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
        model_write(addr, data, strb, eresp);
        chk($sformatf("rnd%0d b_resp @%08h", i, addr), {30'd0, resp}, {30'd0, eresp});
      end else begin
        tcr_tcr = $urandom;
        axi_read(addr, $urandom_range(0, 2), rd, resp);
        model_read(addr, erd, eresp);
        chk($sformatf("rnd%0d r_data @%08h", i, addr), rd, erd);
        chk($sformatf("rnd%0d r_resp @%08h", i, addr), {30'd0, resp}, {30'd0, eresp});
      end
      check_model_outputs($sformatf("rnd%0d", i));
    end
    chk("rnd cnt_strobe total", n_cnt_stb - c0, m_cstb);
    chk("rnd tlr_strobe total", n_tlr_stb - t0, m_tstb);
    chk("rnd tcr_strobe total", n_tcr_stb - r0, m_rstb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
